bf16_mac_tree: RTL and testbench
================================

Name: bf16_mac_tree

Overview:
- Pipelined bfloat16 dot-product engine: 8 pairwise products of 16 bf16 operands, reduced by a fixed 3-level adder tree into one bf16 result.
- Sits in the datapath as a streaming MAC stage.
- Accepts a new operand set every cycle; no handshake.

Parameters:
- None. Format fixed to bf16: 1 sign, 8 exponent (bias 127), 7 fraction bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; clock clk.
- in0..in15  input  16 each  bf16 operands. Pairs are (in0,in1), (in2,in3) … (in14,in15).
- out  output  16  bf16 result.

Behaviour:
- Function: out = sum over k=0..7 of in(2k) * in(2k+1).
- Products: p0 = in0*in1, p1 = in2*in3, … p7 = in14*in15.
- Reduction order is fixed: ((p0+p1)+(p2+p3)) + ((p4+p5)+(p6+p7)).
- Rounding: every multiply and every add rounds to bf16, round-to-nearest-even.
- Subnormals: flushed to zero. Subnormal inputs are treated as signed zero, and any subnormal result is flushed to signed zero.
- Overflow: result magnitude ≥ 2^128 after rounding → ±Inf (0x7F80 / 0xFF80).
- Zeros:
  - x*0 = zero, with sign = XOR of operand signs.
  - Exact cancellation, and (+0)+(−0), give +0 (0x0000).
  - (−0)+(−0) = −0.
- Infinities:
  - Inf*finite-nonzero = Inf, sign = XOR of operand signs.
  - Inf + same-sign Inf = that Inf.
- NaN: any NaN operand, Inf*0, or Inf + opposite-sign Inf produces the canonical quiet NaN 0x7FC0. NaN propagates through all later tree levels.
- Pipeline, latency 2 rising edges:
  - Stage 1: all 16 inputs are registered at edge k.
  - Stage 2: products and tree are combinational from the stage-1 registers. The result is registered into out at edge k+1.
  - out holds that result until edge k+2.
  - Throughput is 1 operand set per cycle, and consecutive sets do not interfere.
- Reset, sampled at the rising edge when reset==0:
  - Stage-1 registers and out clear to 0x0000.
  - While reset stays low, out stays 0x0000.
  - Asserting reset mid-stream discards all in-flight sets.
  - First valid result appears 2 edges after the first edge with reset==1.
- Output is driven only from the register, never combinationally from the inputs.

Test Plan:
- Reset: hold reset=0 for 2 edges with arbitrary inputs → out=0x0000; release, apply all-zero inputs → out stays 0x0000.
- Positive: in0=0x3F80, in1=0x4000, in2=0x4040, in3=0x4080, rest 0 (1*2+3*4) → out=0x4160 two edges after the set is applied. Also check 16 inputs all 0x3F80 → 0x4100 (8.0).
- Negative/zero: in0=0xBF80, in1=0x4000, rest 0 → 0xC000. Set in1=0x40A0, in3=0x40C0, rest 0 → 0x0000. Set in0=0x3F80, in1=0x4000, in2=0xBF80, in3=0x4000 → 0x0000 (+0).
- Specials:
  - in0=0x7F80, in1=0x3F80 → 0x7F80.
  - in0=0x7F80, in1=0x3F80, in2=0xFF80, in3=0x3F80 → 0x7FC0.
  - in0=0x7F80, in1=0x0000 → 0x7FC0.
  - in0=0x7FC5 with any in1 → 0x7FC0.
- Overflow/FTZ:
  - in0=0x7F00, in1=0x4000 → 0x7F80.
  - in0=0x0001, in1=0x3F80 → 0x0000.
  - in0=0x0080, in1=0x3F00 → 0x0000 (flushed result).
- Back-to-back streaming: present three different sets on three consecutive cycles → outputs appear on three consecutive cycles, in order, each matching its own set. Assert reset=0 mid-stream → out=0x0000 and no stale result emerges after release.

Source files
------------

// File: rtl/bf16_mac_tree.sv
// Two-stage bfloat16 dot product: sixteen operands are registered, then eight products
// are reduced by a fixed balanced adder tree into a registered bf16 result.
module bf16_mac_tree (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in0,
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic [15:0] in3,
    input  logic [15:0] in4,
    input  logic [15:0] in5,
    input  logic [15:0] in6,
    input  logic [15:0] in7,
    input  logic [15:0] in8,
    input  logic [15:0] in9,
    input  logic [15:0] in10,
    input  logic [15:0] in11,
    input  logic [15:0] in12,
    input  logic [15:0] in13,
    input  logic [15:0] in14,
    input  logic [15:0] in15,
    output logic [15:0] out
);

    localparam logic [15:0] QNAN = 16'h7FC0;

    logic [15:0] in_vec [16];
    logic [15:0] op_p0  [16];
    logic [15:0] prod_p1 [8];
    logic [15:0] lvl1_p1 [4];
    logic [15:0] lvl2_p1 [2];
    logic [15:0] sum_p1;

    assign in_vec = '{in0, in1, in2, in3, in4, in5, in6, in7,
                      in8, in9, in10, in11, in12, in13, in14, in15};

    // Round-to-nearest-even on {1,f} with guard/sticky, then overflow to Inf or flush to zero.
    function automatic logic [15:0] round_pack(input logic s, input logic signed [10:0] e,
                                               input logic [6:0] f, input logic g,
                                               input logic st);
        logic [8:0]        m;
        logic signed [10:0] er;
        logic [6:0]        fo;
        logic [15:0]       r;
        m  = {2'b01, f} + {8'b0, g & (st | f[0])};
        er = e;
        fo = m[6:0];
        if (m[8]) begin
            er = e + 11'sd1;
            fo = m[7:1];
        end
        if (er >= 11'sd255)    r = {s, 8'hFF, 7'h00};
        else if (er <= 11'sd0) r = {s, 15'h0000};
        else                   r = {s, er[7:0], fo};
        return r;
    endfunction

    function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
        logic              an, ai, az, bn, bi, bz, s;
        logic [15:0]       prod;
        logic signed [10:0] e;
        logic [15:0]       r;
        an = (a[14:7] == 8'hFF) && (a[6:0] != 7'h0);
        ai = (a[14:7] == 8'hFF) && (a[6:0] == 7'h0);
        az = (a[14:7] == 8'h00);
        bn = (b[14:7] == 8'hFF) && (b[6:0] != 7'h0);
        bi = (b[14:7] == 8'hFF) && (b[6:0] == 7'h0);
        bz = (b[14:7] == 8'h00);
        s  = a[15] ^ b[15];
        prod = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
        e    = $signed({3'b000, a[14:7]}) + $signed({3'b000, b[14:7]}) - 11'sd127;
        if (an || bn || (ai && bz) || (bi && az)) r = QNAN;
        else if (ai || bi)                        r = {s, 8'hFF, 7'h00};
        else if (az || bz)                        r = {s, 15'h0000};
        else if (prod[15])                        r = round_pack(s, e + 11'sd1, prod[14:8], prod[7], |prod[6:0]);
        else                                      r = round_pack(s, e, prod[13:7], prod[6], |prod[5:0]);
        return r;
    endfunction

    function automatic logic [15:0] bf16_add(input logic [15:0] a, input logic [15:0] b);
        logic              an, ai, az, bn, bi, bz;
        logic [15:0]       x, y, r;
        logic [7:0]        d;
        logic [24:0]       ma, mf, mb, sum;
        logic [23:0]       norm;
        logic [4:0]        pos;
        logic signed [10:0] e;
        an = (a[14:7] == 8'hFF) && (a[6:0] != 7'h0);
        ai = (a[14:7] == 8'hFF) && (a[6:0] == 7'h0);
        az = (a[14:7] == 8'h00);
        bn = (b[14:7] == 8'hFF) && (b[6:0] != 7'h0);
        bi = (b[14:7] == 8'hFF) && (b[6:0] == 7'h0);
        bz = (b[14:7] == 8'h00);
        if (a[14:0] >= b[14:0]) begin x = a; y = b; end
        else                    begin x = b; y = a; end
        d  = x[14:7] - y[14:7];
        ma = {2'b01, x[6:0], 16'h0};
        mf = {2'b01, y[6:0], 16'h0};
        // Bits shifted past the 16 extension bits only matter as a sticky flag.
        if (d > 8'd24) mb = 25'd1;
        else           mb = (mf >> d) | {24'h0, |(mf & ((25'd1 << d) - 25'd1))};
        sum = (x[15] == y[15]) ? ma + mb : ma - mb;
        pos = 5'd0;
        for (int i = 0; i < 25; i++)
            if (sum[i]) pos = 5'(i);
        norm = 24'(sum << (5'd24 - pos));
        e    = $signed({3'b000, x[14:7]}) + $signed({6'b000000, pos}) - 11'sd23;
        if (an || bn || (ai && bi && (a[15] != b[15]))) r = QNAN;
        else if (ai)                                    r = a;
        else if (bi)                                    r = b;
        else if (az && bz)                              r = {a[15] & b[15], 15'h0000};
        else if (az)                                    r = b;
        else if (bz)                                    r = a;
        else if (sum == 25'd0)                          r = 16'h0000;
        else r = round_pack(x[15], e, norm[23:17], norm[16], |norm[15:0]);
        return r;
    endfunction

    // Stage 1: operand registers
    always_ff @(posedge clk) begin
        for (int i = 0; i < 16; i++)
            op_p0[i] <= (!reset) ? 16'h0000 : in_vec[i];
    end

    always_comb begin
        for (int k = 0; k < 8; k++) prod_p1[k] = bf16_mul(op_p0[2*k], op_p0[2*k+1]);
        for (int j = 0; j < 4; j++) lvl1_p1[j] = bf16_add(prod_p1[2*j], prod_p1[2*j+1]);
        for (int j = 0; j < 2; j++) lvl2_p1[j] = bf16_add(lvl1_p1[2*j], lvl1_p1[2*j+1]);
        sum_p1 = bf16_add(lvl2_p1[0], lvl2_p1[1]);
    end

    // Stage 2: result register
    always_ff @(posedge clk) begin
        if (!reset) out <= 16'h0000;
        else        out <= sum_p1;
    end

endmodule

// File: tb/tb_bf16_mac_tree.sv
// Bench for bf16_mac_tree: directed and random operand sets compared against a
// real-arithmetic bf16 reference model through a two-deep expected-result delay line.
module tb_bf16_mac_tree;

    logic        clk;
    logic        reset;
    logic [15:0] din [16];
    logic [15:0] dout;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_s1, exp_out;
    string       tag_s1, tag_out;

    bf16_mac_tree dut (
        .clk(clk), .reset(reset),
        .in0(din[0]),   .in1(din[1]),   .in2(din[2]),   .in3(din[3]),
        .in4(din[4]),   .in5(din[5]),   .in6(din[6]),   .in7(din[7]),
        .in8(din[8]),   .in9(din[9]),   .in10(din[10]), .in11(din[11]),
        .in12(din[12]), .in13(din[13]), .in14(din[14]), .in15(din[15]),
        .out(dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: out=%h expected=%h", tag, got, expv);
        end
    endtask

    function automatic real to_real(input logic [15:0] h);
        logic [10:0] e11;
        e11 = 11'(h[14:7]) + 11'd896;
        return $bitstoreal({h[15], e11, h[6:0], 45'h0});
    endfunction

    function automatic logic [15:0] to_bf16(input real x);
        logic s;
        real  ax, sc, fr;
        int   e, r, be;
        s  = (x < 0.0);
        ax = s ? -x : x;
        e  = 0;
        while (ax >= 2.0) begin ax = ax / 2.0; e++; end
        while (ax < 1.0)  begin ax = ax * 2.0; e--; end
        sc = ax * 128.0;
        r  = $rtoi(sc);
        fr = sc - r;
        if (fr > 0.5 || (fr == 0.5 && r[0])) r++;
        if (r == 256) begin r = 128; e++; end
        be = e + 127;
        if (be >= 255) return {s, 8'hFF, 7'h00};
        if (be <= 0)   return {s, 15'h0000};
        return {s, 8'(be), 7'(r - 128)};
    endfunction

    function automatic bit is_nan(input logic [15:0] h);
        return h[14:7] == 8'hFF && h[6:0] != 0;
    endfunction
    function automatic bit is_inf(input logic [15:0] h);
        return h[14:7] == 8'hFF && h[6:0] == 0;
    endfunction
    function automatic bit is_zero(input logic [15:0] h);
        return h[14:7] == 8'h00;
    endfunction

    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic s;
        s = a[15] ^ b[15];
        if (is_nan(a) || is_nan(b) || (is_inf(a) && is_zero(b)) || (is_inf(b) && is_zero(a)))
            return 16'h7FC0;
        if (is_inf(a) || is_inf(b))   return {s, 15'h7F80};
        if (is_zero(a) || is_zero(b)) return {s, 15'h0000};
        return to_bf16(to_real(a) * to_real(b));
    endfunction

    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        real r;
        if (is_nan(a) || is_nan(b)) return 16'h7FC0;
        if (is_inf(a) && is_inf(b)) return (a[15] == b[15]) ? a : 16'h7FC0;
        if (is_inf(a))              return a;
        if (is_inf(b))              return b;
        if (is_zero(a) && is_zero(b)) return {a[15] & b[15], 15'h0000};
        if (is_zero(a))             return b;
        if (is_zero(b))             return a;
        r = to_real(a) + to_real(b);
        if (r == 0.0) return 16'h0000;
        return to_bf16(r);
    endfunction

    function automatic logic [15:0] ref_dot(input logic [15:0] v [16]);
        logic [15:0] p [8];
        for (int k = 0; k < 8; k++) p[k] = ref_mul(v[2*k], v[2*k+1]);
        return ref_add(ref_add(ref_add(p[0], p[1]), ref_add(p[2], p[3])),
                       ref_add(ref_add(p[4], p[5]), ref_add(p[6], p[7])));
    endfunction

    function automatic logic [15:0] rand_op();
        int sel;
        sel = $urandom_range(0, 99);
        case (sel)
            0: return {1'($urandom), 15'h0000};
            1: return {1'($urandom), 15'h7F80};
            2: return {1'($urandom), 8'hFF, 7'($urandom_range(1, 127))};
            3: return {1'($urandom), 8'h00, 7'($urandom_range(1, 127))};
            4: return {1'($urandom), 8'($urandom_range(240, 254)), 7'($urandom)};
            5: return {1'($urandom), 8'($urandom_range(1, 10)), 7'($urandom)};
            default: return {1'($urandom), 8'($urandom_range(110, 140)), 7'($urandom)};
        endcase
    endfunction

    // One clock: advance the expected-result delay line, then check out after the edge.
    task automatic step(input string tag);
        logic [15:0] nxt;
        nxt = ref_dot(din);
        @(posedge clk);
        if (!reset) begin
            exp_out = 16'h0000; tag_out = "reset";
            exp_s1  = 16'h0000; tag_s1  = "reset";
        end else begin
            exp_out = exp_s1; tag_out = tag_s1;
            exp_s1  = nxt;    tag_s1  = tag;
        end
        #1 chk(tag_out, dout, exp_out);
    endtask

    task automatic set4(input logic [15:0] a0, input logic [15:0] a1,
                        input logic [15:0] a2, input logic [15:0] a3);
        for (int i = 0; i < 16; i++) din[i] = 16'h0000;
        din[0] = a0; din[1] = a1; din[2] = a2; din[3] = a3;
    endtask

    task automatic set_rand();
        for (int i = 0; i < 16; i++) din[i] = rand_op();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: out=%h expected=finish", dout);
        $fatal(1, "timeout");
    end

    initial begin
        exp_s1 = 16'h0000; exp_out = 16'h0000; tag_s1 = "none"; tag_out = "none";
        reset = 1'b0;
        set_rand(); step("rst_hold0");
        set_rand(); step("rst_hold1");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin set4(0, 0, 0, 0); step("zeros"); end

        set4(16'h3F80, 16'h4000, 16'h4040, 16'h4080); step("pos_1x2p3x4");
        for (int i = 0; i < 16; i++) din[i] = 16'h3F80;
        step("all_ones");
        set4(16'hBF80, 16'h4000, 0, 0);               step("neg_m1x2");
        set4(0, 16'h40A0, 0, 16'h40C0);               step("zero_prods");
        set4(16'h3F80, 16'h4000, 16'hBF80, 16'h4000); step("cancel_pos0");
        set4(16'h7F80, 16'h3F80, 0, 0);               step("inf_x1");
        set4(16'h7F80, 16'h3F80, 16'hFF80, 16'h3F80); step("inf_minus_inf");
        set4(16'h7F80, 16'h0000, 0, 0);               step("inf_x0");
        set4(16'h7FC5, 16'($urandom), 0, 0);          step("nan_in");
        set4(16'h7F00, 16'h4000, 0, 0);               step("overflow");
        set4(16'h0001, 16'h3F80, 0, 0);               step("sub_in_ftz");
        set4(16'h0080, 16'h3F00, 0, 0);               step("sub_out_ftz");
        set4(16'h8000, 16'h3F80, 16'h8000, 16'h3F80); step("negz_sum");
        set4(16'h8000, 16'h3F80, 16'h0000, 16'h3F80); step("mixz_sum");

        for (int i = 0; i < 300; i++) begin set_rand(); step("random"); end

        set_rand(); step("stream_a");
        set_rand(); step("stream_b");
        set_rand(); step("stream_c");
        reset = 1'b0;
        set_rand(); step("mid_rst");
        reset = 1'b1;
        set4(16'h3F80, 16'h4000, 0, 0); step("post_rst_a");
        set_rand();                     step("post_rst_b");
        for (int i = 0; i < 100; i++) begin set_rand(); step("random2"); end
        for (int i = 0; i < 2; i++) begin set4(0, 0, 0, 0); step("flush"); end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
